// File: rtl/fifo_wr_adapter.sv
`default_nettype none
// ============================================================================
// fifo_wr_adapter : write-domain front end for the async FIFO. Two-entry skid
//                   buffer between a valid/ready producer and the FIFO write
//                   port, with saturating write and stall statistics.
// Revision        : 1.0 - initial release
// ============================================================================
module fifo_wr_adapter #(
  parameter int DSIZE       = 8,
  parameter int CNTW        = 16,
  parameter int AF_THROTTLE = 0
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [DSIZE-1:0] s_data,
  input  logic             flush,
  output logic             winc,
  output logic [DSIZE-1:0] wdata,
  input  logic             wfull,
  input  logic             awfull,
  output logic [CNTW-1:0]  wr_count,
  output logic [CNTW-1:0]  stall_count
);

  localparam logic            c_af_throttle = (AF_THROTTLE != 0);
  localparam logic [CNTW-1:0] c_cnt_max     = '1;

  logic [DSIZE-1:0] r_head;
  logic [DSIZE-1:0] r_tail;
  logic [1:0]       r_occ;
  logic             r_rdy_q;
  logic [CNTW-1:0]  r_wr_count;
  logic [CNTW-1:0]  r_stall_count;

  logic             w_acc;
  logic             w_drain;
  logic             w_stall;
  logic [1:0]       w_occ_drained;
  logic [1:0]       w_occ_next;
  logic             w_rdy_next;

  // Ready is purely registered; flush is the only combinational gate on it.
  assign s_ready = r_rdy_q & ~flush;
  assign w_acc   = s_valid & s_ready;
  assign w_drain = (r_occ != 2'd0) & ~wfull & ~flush;
  assign w_stall = (r_occ != 2'd0) & wfull & ~flush;

  assign winc        = w_drain;
  assign wdata       = r_head;
  assign wr_count    = r_wr_count;
  assign stall_count = r_stall_count;

  always_comb begin
    w_occ_drained = r_occ - {1'b0, w_drain};
    w_occ_next    = flush ? 2'd0 : (w_occ_drained + {1'b0, w_acc});
    w_rdy_next    = (w_occ_next < 2'd2) &
                    ~(c_af_throttle & awfull & (w_occ_next != 2'd0));
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_occ   <= 2'd0;
      r_rdy_q <= 1'b0;
    end else begin
      r_occ   <= w_occ_next;
      r_rdy_q <= w_rdy_next;
    end
  end

  // Drain shifts tail into head; a new word lands in head only when the
  // buffer is empty after that shift, which keeps acceptance order.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_drain) begin
        r_head <= r_tail;
      end
      if (w_acc) begin
        if (w_occ_drained == 2'd0) begin
          r_head <= s_data;
        end else begin
          r_tail <= s_data;
        end
      end
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_wr_count    <= '0;
      r_stall_count <= '0;
    end else begin
      if (w_drain && (r_wr_count != c_cnt_max)) begin
        r_wr_count <= r_wr_count + CNTW'(1);
      end
      if (w_stall && (r_stall_count != c_cnt_max)) begin
        r_stall_count <= r_stall_count + CNTW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_adapter.sv
`default_nettype none
// Bench for fifo_wr_adapter: directed plan steps plus a random phase, checked
// against a queue-based model; three instances cover AF_THROTTLE and CNTW=4.
module tb_fifo_wr_adapter;

  logic       clk = 1'b0;
  logic       wrst_n;
  logic       s_valid;
  logic [7:0] s_data;
  logic       flush;
  logic       wfull;
  logic       awfull;

  logic        s_ready0, winc0, s_ready1, winc1, s_ready2, winc2;
  logic [7:0]  wdata0, wdata1, wdata2;
  logic [15:0] wr_count0, stall_count0, wr_count1, stall_count1;
  logic [3:0]  wr_count2, stall_count2;

  always #5 clk = ~clk;

  fifo_wr_adapter #(.DSIZE(8), .CNTW(16), .AF_THROTTLE(0)) dut0 (
    .wclk(clk), .wrst_n(wrst_n), .s_valid(s_valid), .s_ready(s_ready0),
    .s_data(s_data), .flush(flush), .winc(winc0), .wdata(wdata0),
    .wfull(wfull), .awfull(awfull), .wr_count(wr_count0), .stall_count(stall_count0));

  fifo_wr_adapter #(.DSIZE(8), .CNTW(16), .AF_THROTTLE(1)) dut_af (
    .wclk(clk), .wrst_n(wrst_n), .s_valid(s_valid), .s_ready(s_ready1),
    .s_data(s_data), .flush(flush), .winc(winc1), .wdata(wdata1),
    .wfull(wfull), .awfull(awfull), .wr_count(wr_count1), .stall_count(stall_count1));

  fifo_wr_adapter #(.DSIZE(8), .CNTW(4), .AF_THROTTLE(0)) dut_sat (
    .wclk(clk), .wrst_n(wrst_n), .s_valid(s_valid), .s_ready(s_ready2),
    .s_data(s_data), .flush(flush), .winc(winc2), .wdata(wdata2),
    .wfull(wfull), .awfull(awfull), .wr_count(wr_count2), .stall_count(stall_count2));

  int checks = 0;
  int errors = 0;

  // Reference models: q0 serves dut0 and dut_sat, q1 serves dut_af.
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  bit         rdy0, rdy1;
  int         wr0, st0, wr1, st1;

  logic [7:0] src[$];
  logic [7:0] wlog[$];
  bit         last_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] satv(input int n, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  task automatic model_reset();
    q0.delete(); q1.delete();
    rdy0 = 0; rdy1 = 0;
    wr0 = 0; st0 = 0; wr1 = 0; st1 = 0;
  endtask

  task automatic tick();
    bit ew0, ew1, d0, s0, a0, d1, s1, a1;
    #1;
    ew0 = (q0.size() != 0) && !wfull && !flush && wrst_n;
    ew1 = (q1.size() != 0) && !wfull && !flush && wrst_n;
    chk("s_ready", s_ready0, rdy0 && !flush);
    chk("winc", winc0, ew0);
    if (ew0) chk("wdata", wdata0, q0[0]);
    chk("wr_count", wr_count0, satv(wr0, 16));
    chk("stall_count", stall_count0, satv(st0, 16));
    chk("sat_s_ready", s_ready2, rdy0 && !flush);
    chk("sat_winc", winc2, ew0);
    if (ew0) chk("sat_wdata", wdata2, q0[0]);
    chk("sat_wr_count", wr_count2, satv(wr0, 4));
    chk("sat_stall_count", stall_count2, satv(st0, 4));
    chk("af_s_ready", s_ready1, rdy1 && !flush);
    chk("af_winc", winc1, ew1);
    if (ew1) chk("af_wdata", wdata1, q1[0]);
    chk("af_wr_count", wr_count1, satv(wr1, 16));
    chk("af_stall_count", stall_count1, satv(st1, 16));
    if (winc0 === 1'b1) wlog.push_back(wdata0);
    last_acc = (s_valid === 1'b1) && (s_ready0 === 1'b1);
    @(posedge clk);
    if (wrst_n) begin
      d0 = (q0.size() != 0) && !wfull && !flush;
      s0 = (q0.size() != 0) && wfull && !flush;
      a0 = s_valid && rdy0 && !flush;
      d1 = (q1.size() != 0) && !wfull && !flush;
      s1 = (q1.size() != 0) && wfull && !flush;
      a1 = s_valid && rdy1 && !flush;
      if (d0) begin void'(q0.pop_front()); wr0++; end
      if (s0) st0++;
      if (a0) q0.push_back(s_data);
      if (flush) q0.delete();
      rdy0 = (q0.size() < 2);
      if (d1) begin void'(q1.pop_front()); wr1++; end
      if (s1) st1++;
      if (a1) q1.push_back(s_data);
      if (flush) q1.delete();
      rdy1 = (q1.size() < 2) && !(awfull && (q1.size() != 0));
    end
    @(negedge clk);
  endtask

  // Upstream source: offers src[0] until it is accepted.
  task automatic src_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      s_valid = (src.size() != 0);
      if (src.size() != 0) s_data = src[0];
      tick();
      if (last_acc && src.size() != 0) void'(src.pop_front());
    end
    s_valid = 1'b0;
  endtask

  initial begin
    wrst_n = 1'b1; s_valid = 1'b0; s_data = '0; flush = 1'b0; wfull = 1'b0; awfull = 1'b0;
    model_reset();
    #2 wrst_n = 1'b0;
    @(negedge clk);

    // Reset state, release, then a 16-word back-to-back stream.
    tick(); tick();
    wrst_n = 1'b1;
    tick();
    chk("ready_after_release", s_ready0, 1'b1);
    wlog.delete();
    for (int i = 0; i < 16; i++) src.push_back(8'(i));
    src_ticks(16);
    chk("stream_all_accepted", src.size(), 0);
    src_ticks(2);
    chk("stream_write_count", wlog.size(), 16);
    for (int i = 0; i < 16; i++) if (i < wlog.size()) chk("stream_wdata", wlog[i], i);
    chk("stream_wr_count", wr_count0, 16);

    // Full stall with 0xA1 buffered, then release.
    wlog.delete();
    wfull = 1'b1;
    src.push_back(8'hA1);
    src_ticks(1);
    src.push_back(8'hA2); src.push_back(8'hA3); src.push_back(8'hA4);
    src_ticks(10);
    chk("stall_only_a2_accepted", src.size(), 2);
    chk("stall_no_writes", wlog.size(), 0);
    chk("stall_count_10", stall_count0, 10);
    wfull = 1'b0;
    src_ticks(6);
    chk("stall_write_count", wlog.size(), 4);
    for (int i = 0; i < 4; i++) if (i < wlog.size()) chk("stall_order", wlog[i], 8'hA1 + i);

    // wfull falls while occ=2 and s_valid is high.
    wlog.delete();
    wfull = 1'b1;
    src.push_back(8'hB1); src.push_back(8'hB2);
    src_ticks(2);
    wfull = 1'b0; s_valid = 1'b1; s_data = 8'hB3;
    tick();
    chk("simul_no_accept", last_acc, 1'b0);
    chk("simul_one_write", wlog.size(), 1);
    chk("simul_ready_next", s_ready0, 1'b1);
    src.push_back(8'hB3);
    src_ticks(4);
    chk("simul_write_count", wlog.size(), 3);
    for (int i = 0; i < 3; i++) if (i < wlog.size()) chk("simul_order", wlog[i], 8'hB1 + i);

    // Flush with two buffered words and a third on offer.
    wlog.delete();
    wfull = 1'b1;
    src.push_back(8'h55); src.push_back(8'h66);
    src_ticks(2);
    flush = 1'b1; s_valid = 1'b1; s_data = 8'h77; wfull = 1'b0;
    tick();
    chk("flush_no_accept", last_acc, 1'b0);
    flush = 1'b0; s_valid = 1'b0;
    tick(); tick(); tick();
    chk("flush_nothing_written", wlog.size(), 0);
    chk("flush_wr_count", wr_count0, 23);

    // Almost-full throttling, both parameter settings under one stimulus.
    wfull = 1'b1; awfull = 1'b1; s_valid = 1'b1; s_data = 8'hC1;
    tick();
    s_valid = 1'b0;
    chk("af_throttle_ready", s_ready1, 1'b0);
    chk("af_off_ready", s_ready0, 1'b1);
    tick();
    awfull = 1'b0; wfull = 1'b0;
    tick(); tick(); tick();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data  = 8'($urandom);
      wfull   = ($urandom_range(0, 2) == 0);
      awfull  = ($urandom_range(0, 3) == 0);
      flush   = ($urandom_range(0, 15) == 0);
      tick();
    end
    s_valid = 1'b0; wfull = 1'b0; awfull = 1'b0; flush = 1'b0;
    tick(); tick(); tick();

    // Saturation and asynchronous reset mid-cycle.
    wrst_n = 1'b0;
    model_reset();
    tick();
    wrst_n = 1'b1;
    tick();
    for (int i = 0; i < 21; i++) src.push_back(8'(i));
    src_ticks(21);
    chk("sat_all_accepted", src.size(), 0);
    chk("sat_wide_count_20", wr_count0, 20);
    chk("sat_narrow_count_15", wr_count2, 15);
    chk("sat_winc_pending", winc0, 1'b1);
    #2 wrst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_winc", winc0, 1'b0);
    chk("async_rst_s_ready", s_ready0, 1'b0);
    chk("async_rst_wr_count", wr_count0, 0);
    chk("async_rst_sat_wr_count", wr_count2, 0);
    chk("async_rst_stall_count", stall_count0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
